imem_access_ctrl: RTL

- Sequences and shares the byte-addressed instruction memory between two requesters: the program loader (byte-serial writes) and the fetch stage (10-byte instruction reads).
- After reset, holds fetch stalled until the loader signals the last byte.
- Then arbitrates per cycle, with fetch priority and a starvation guard for the loader.
- Registers the fetch response: byte0 plus bytes 1..9, and the out-of-range error.

---
 rtl/imem_access_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/imem_access_ctrl.sv
// rtl/imem_access_ctrl.sv - instruction memory sharing between program loader and 10-byte fetch.
// Optional IMEM_LOAD_CHECKSUM_EN adds ld_csum, a mod-256 sum of bytes actually written.
module imem_access_ctrl #(
  parameter int MEM_BYTES  = 1025,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [63:0] ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_err,
  input  logic        f_req,
  input  logic [63:0] f_pc,
  output logic        f_gnt,
  output logic        f_stall,
  output logic        f_valid,
  output logic [7:0]  f_byte0,
  output logic [71:0] f_byte19,
  output logic        f_imem_err,
  output logic        mem_we,
  output logic [63:0] mem_waddr,
  output logic [7:0]  mem_wdata,
  output logic [63:0] mem_raddr,
  input  logic [79:0] mem_rdata,
  output logic        loaded
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [7:0]  ld_csum
`endif
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic {LOAD, RUN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] starve_cnt;
  logic          force_wr;
  logic          ld_in_range;
  logic          fetch_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == LOAD && ld_valid && ld_last) state_nxt = RUN;
  end

  // Fetch wins contention unless the loader has been denied STARVE_MAX cycles in a row.
  always_comb begin
    force_wr    = 1'b0;
    ld_ready    = 1'b0;
    f_gnt       = 1'b0;
    f_stall     = 1'b1;
    loaded      = 1'b0;
    ld_in_range = ld_addr < MEM_LIMIT;
    if (state == LOAD) begin
      ld_ready = ld_valid;
    end else begin
      loaded   = 1'b1;
      force_wr = f_req && ld_valid && (starve_cnt == CNT_MAX);
      f_gnt    = f_req && !force_wr;
      ld_ready = ld_valid && (!f_req || force_wr);
      f_stall  = f_req && !f_gnt;
    end
    mem_we = ld_ready && ld_in_range;
  end

  assign mem_waddr = ld_addr;
  assign mem_wdata = ld_data;
  assign mem_raddr = f_pc;
  assign fetch_err = (f_pc + 64'd9) >= MEM_LIMIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      ld_err     <= 1'b0;
      f_valid    <= 1'b0;
      f_byte0    <= '0;
      f_byte19   <= '0;
      f_imem_err <= 1'b0;
    end else begin
      if (ld_valid && !ld_ready) begin
        if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      ld_err  <= ld_ready && !ld_in_range;
      f_valid <= f_gnt;
      if (f_gnt) begin
        f_imem_err <= fetch_err;
        f_byte0    <= fetch_err ? 8'h00  : mem_rdata[79:72];
        f_byte19   <= fetch_err ? 72'h0  : mem_rdata[71:0];
      end
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ld_csum <= 8'h00;
    else if (mem_we) ld_csum <= ld_csum + ld_data;
  end
`endif

endmodule
